// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
// Memory access and write-back stage of a simple in-order RV32 pipeline.
// ALU results are registered straight to the write-back port. Loads and
// stores go out over a request/ack data-memory port. Loads are
// size-extracted and sign- or zero-extended before write-back.
//
// Ports
//   clk_100MHz, arst_n      : clock, asynchronous active-low reset
//   ex_*_i                  : EX/MEM slot (valid, rd write, rd index, ALU
//                             result / effective address, load/store,
//                             funct3 size code, store data)
//   dmem_req_o/we_o/addr_o  : memory request, held until ack inclusive
//   dmem_wdata_o/wstrb_o    : lane-replicated store data, byte enables
//   dmem_ack_i/rdata_i      : completion strobe and same-cycle read word
//   stall_req_o             : upstream holds EX/MEM while high
//   misalign_o              : one-cycle pulse for a misaligned access
//   w_e_o/w_addr_o/w_data_o : register-file write-back port
// ---------------------------------------------------------------------------
module mem_wb_stage (
    input  logic        clk_100MHz,
    input  logic        arst_n,
    input  logic        ex_valid_i,
    input  logic        ex_w_e_i,
    input  logic [4:0]  ex_w_addr_i,
    input  logic [31:0] ex_alu_result_i,
    input  logic        ex_mem_rd_i,
    input  logic        ex_mem_wr_i,
    input  logic [2:0]  ex_funct3_i,
    input  logic [31:0] ex_store_data_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_wstrb_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_req_o,
    output logic        misalign_o,
    output logic        w_e_o,
    output logic [4:0]  w_addr_o,
    output logic [31:0] w_data_o
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic        is_mem, misaligned, accept, alu_wb;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [4:0]  rd_q;

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] s;
        case (f3[1:0])
            2'b00:   s = 4'b0001 << off;
            2'b01:   s = 4'b0011 << off;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        case (f3[1:0])
            2'b00:   r = {4{d[7:0]}};
            2'b01:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] d);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        r;
        b = d[{off, 3'b000} +: 8];
        h = d[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  r = 32'(b);
            3'b001:  r = 32'(h);
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = d;
        endcase
        return r;
    endfunction

    always_comb begin
        is_mem     = ex_mem_rd_i | ex_mem_wr_i;
        misaligned = ((ex_funct3_i[1:0] == 2'b01) && ex_alu_result_i[0]) ||
                     ((ex_funct3_i == 3'b010) && (ex_alu_result_i[1:0] != 2'b00));
        accept     = ex_valid_i && is_mem && !misaligned;
        alu_wb     = ex_valid_i && !is_mem;
    end

    always_ff @(posedge clk_100MHz or negedge arst_n) begin
        if (!arst_n) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Stall is gated by reset so it reads 0 while arst_n is low even if EX
    // presents a memory op.
    always_comb begin
        state_d     = state_q;
        stall_req_o = 1'b0;
        case (state_q)
            IDLE: begin
                stall_req_o = arst_n && accept;
                if (accept) state_d = BUSY;
            end
            BUSY: begin
                stall_req_o = arst_n && !dmem_ack_i;
                if (dmem_ack_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---- request capture / write-back register stage ----
    always_ff @(posedge clk_100MHz or negedge arst_n) begin
        if (!arst_n) begin
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= 32'd0;
            dmem_wdata_o <= 32'd0;
            dmem_wstrb_o <= 4'd0;
            funct3_q     <= 3'd0;
            off_q        <= 2'd0;
            rd_q         <= 5'd0;
            misalign_o   <= 1'b0;
            w_e_o        <= 1'b0;
            w_addr_o     <= 5'd0;
            w_data_o     <= 32'd0;
        end else begin
            w_e_o      <= 1'b0;
            misalign_o <= 1'b0;
            if (state_q == IDLE) begin
                misalign_o <= ex_valid_i && is_mem && misaligned;
                if (accept) begin
                    dmem_req_o   <= 1'b1;
                    dmem_we_o    <= ex_mem_wr_i;
                    dmem_addr_o  <= {ex_alu_result_i[31:2], 2'b00};
                    dmem_wdata_o <= store_lanes(ex_funct3_i, ex_store_data_i);
                    dmem_wstrb_o <= ex_mem_wr_i ? store_strb(ex_funct3_i, ex_alu_result_i[1:0]) : 4'd0;
                    funct3_q     <= ex_funct3_i;
                    off_q        <= ex_alu_result_i[1:0];
                    rd_q         <= ex_w_addr_i;
                end else if (alu_wb) begin
                    w_e_o    <= ex_w_e_i && (ex_w_addr_i != 5'd0);
                    w_addr_o <= ex_w_addr_i;
                    w_data_o <= ex_alu_result_i;
                end
            end else if (dmem_ack_i) begin
                dmem_req_o <= 1'b0;
                // Stores never write back; loads only when rd is a real register.
                if (!dmem_we_o) begin
                    w_e_o    <= (rd_q != 5'd0);
                    w_addr_o <= rd_q;
                    w_data_o <= load_extract(funct3_q, off_q, dmem_rdata_i);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

    logic        clk_100MHz = 1'b0;
    logic        arst_n;
    logic        ex_valid_i, ex_w_e_i, ex_mem_rd_i, ex_mem_wr_i;
    logic [4:0]  ex_w_addr_i;
    logic [31:0] ex_alu_result_i, ex_store_data_i;
    logic [2:0]  ex_funct3_i;
    logic        dmem_req_o, dmem_we_o, dmem_ack_i;
    logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
    logic [3:0]  dmem_wstrb_o;
    logic        stall_req_o, misalign_o, w_e_o;
    logic [4:0]  w_addr_o;
    logic [31:0] w_data_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Values captured by run_mem
    int          r_req_cnt, r_stall_cnt;
    logic        r_we, r_w_e, r_req_after;
    logic [31:0] r_addr, r_wdata, r_w_data;
    logic [3:0]  r_wstrb;
    logic [4:0]  r_w_addr;

    always #5 clk_100MHz = ~clk_100MHz;

    mem_wb_stage dut (
        .clk_100MHz      (clk_100MHz),
        .arst_n          (arst_n),
        .ex_valid_i      (ex_valid_i),
        .ex_w_e_i        (ex_w_e_i),
        .ex_w_addr_i     (ex_w_addr_i),
        .ex_alu_result_i (ex_alu_result_i),
        .ex_mem_rd_i     (ex_mem_rd_i),
        .ex_mem_wr_i     (ex_mem_wr_i),
        .ex_funct3_i     (ex_funct3_i),
        .ex_store_data_i (ex_store_data_i),
        .dmem_req_o      (dmem_req_o),
        .dmem_we_o       (dmem_we_o),
        .dmem_addr_o     (dmem_addr_o),
        .dmem_wdata_o    (dmem_wdata_o),
        .dmem_wstrb_o    (dmem_wstrb_o),
        .dmem_ack_i      (dmem_ack_i),
        .dmem_rdata_i    (dmem_rdata_i),
        .stall_req_o     (stall_req_o),
        .misalign_o      (misalign_o),
        .w_e_o           (w_e_o),
        .w_addr_o        (w_addr_o),
        .w_data_o        (w_data_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [4:0] rd, input logic [31:0] alu,
                         input logic mrd, input logic mwr, input logic [2:0] f3, input logic [31:0] sd);
        ex_valid_i = v; ex_w_e_i = we; ex_w_addr_i = rd; ex_alu_result_i = alu;
        ex_mem_rd_i = mrd; ex_mem_wr_i = mwr; ex_funct3_i = f3; ex_store_data_i = sd;
    endtask

    task automatic next_cycle();
        @(posedge clk_100MHz);
        #1;
    endtask

    // Issue one aligned memory op, ack it after `waits` wait-state cycles,
    // then present a bubble and capture the write-back the cycle after ack.
    task automatic run_mem(input logic wr, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] addr, input logic [31:0] sd,
                           input int waits, input logic [31:0] rdata);
        drive(1'b1, 1'b1, rd, addr, !wr, wr, f3, sd);
        r_req_cnt = 0;
        r_stall_cnt = 0;
        @(negedge clk_100MHz);
        if (stall_req_o) r_stall_cnt++;
        for (int c = 0; c <= waits; c++) begin
            next_cycle();
            dmem_ack_i   = (c == waits);
            dmem_rdata_i = (c == waits) ? rdata : 32'h5A5A_5A5A;
            @(negedge clk_100MHz);
            if (dmem_req_o)  r_req_cnt++;
            if (stall_req_o) r_stall_cnt++;
            if (c == 0) begin
                r_we = dmem_we_o; r_addr = dmem_addr_o;
                r_wdata = dmem_wdata_o; r_wstrb = dmem_wstrb_o;
            end
        end
        next_cycle();
        dmem_ack_i = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0);
        @(negedge clk_100MHz);
        r_w_e = w_e_o; r_w_addr = w_addr_o; r_w_data = w_data_o; r_req_after = dmem_req_o;
        next_cycle();
    endtask

    initial begin
        arst_n = 1'b0;
        dmem_ack_i = 1'b0;
        dmem_rdata_i = 32'd0;
        // Aligned load presented during reset: stall must still be 0.
        drive(1'b1, 1'b1, 5'd3, 32'h0000_0100, 1'b1, 1'b0, 3'b010, 32'd0);
        #12;
        check("rst_req",    {31'd0, dmem_req_o}, 32'd0);
        check("rst_we",     {31'd0, dmem_we_o}, 32'd0);
        check("rst_addr",   dmem_addr_o, 32'd0);
        check("rst_wdata",  dmem_wdata_o, 32'd0);
        check("rst_wstrb",  {28'd0, dmem_wstrb_o}, 32'd0);
        check("rst_stall",  {31'd0, stall_req_o}, 32'd0);
        check("rst_mis",    {31'd0, misalign_o}, 32'd0);
        check("rst_we_o",   {31'd0, w_e_o}, 32'd0);
        check("rst_waddr",  {27'd0, w_addr_o}, 32'd0);
        check("rst_wdata_o", w_data_o, 32'd0);
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0);
        @(negedge clk_100MHz);
        arst_n = 1'b1;
        next_cycle();

        // ALU op rd=5
        drive(1'b1, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 1'b0, 3'd0, 32'd0);
        @(negedge clk_100MHz);
        check("alu_stall", {31'd0, stall_req_o}, 32'd0);
        next_cycle();
        drive(1'b0, 1'b1, 5'd7, 32'hFFFF_FFFF, 1'b0, 1'b0, 3'd0, 32'd0);
        @(negedge clk_100MHz);
        check("alu_we",    {31'd0, w_e_o}, 32'd1);
        check("alu_waddr", {27'd0, w_addr_o}, 32'd5);
        check("alu_wdata", w_data_o, 32'h1234_5678);
        check("alu_stall2", {31'd0, stall_req_o}, 32'd0);
        next_cycle();
        // ALU op to x0 while checking the bubble result
        drive(1'b1, 1'b1, 5'd0, 32'hCAFE_0000, 1'b0, 1'b0, 3'd0, 32'd0);
        @(negedge clk_100MHz);
        check("bubble_we", {31'd0, w_e_o}, 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0);
        @(negedge clk_100MHz);
        check("x0_we", {31'd0, w_e_o}, 32'd0);
        next_cycle();

        // LB 0x103, two wait states
        run_mem(1'b0, 3'b000, 5'd9, 32'h0000_0103, 32'd0, 2, 32'h80FF_0000);
        check("lb_req_cnt",   r_req_cnt, 32'd3);
        check("lb_stall_cnt", r_stall_cnt, 32'd3);
        check("lb_addr",      r_addr, 32'h0000_0100);
        check("lb_we",        {31'd0, r_we}, 32'd0);
        check("lb_w_e",       {31'd0, r_w_e}, 32'd1);
        check("lb_w_addr",    {27'd0, r_w_addr}, 32'd9);
        check("lb_w_data",    r_w_data, 32'hFFFF_FF80);
        check("lb_req_drop",  {31'd0, r_req_after}, 32'd0);

        // LHU 0x102, immediate ack
        run_mem(1'b0, 3'b101, 5'd10, 32'h0000_0102, 32'd0, 0, 32'h8001_0000);
        check("lhu_req_cnt", r_req_cnt, 32'd1);
        check("lhu_w_e",     {31'd0, r_w_e}, 32'd1);
        check("lhu_w_data",  r_w_data, 32'h0000_8001);

        // LH same word: sign-extended
        run_mem(1'b0, 3'b001, 5'd11, 32'h0000_0102, 32'd0, 1, 32'h8001_0000);
        check("lh_w_data", r_w_data, 32'hFFFF_8001);

        // LBU byte 1
        run_mem(1'b0, 3'b100, 5'd12, 32'h0000_0101, 32'd0, 0, 32'h1122_F344);
        check("lbu_w_data", r_w_data, 32'h0000_00F3);

        // LW aligned
        run_mem(1'b0, 3'b010, 5'd13, 32'h0000_0104, 32'd0, 0, 32'hDEAD_BEEF);
        check("lw_addr",   r_addr, 32'h0000_0104);
        check("lw_w_data", r_w_data, 32'hDEAD_BEEF);

        // LB to x0: no write-back
        run_mem(1'b0, 3'b000, 5'd0, 32'h0000_0100, 32'd0, 0, 32'h0000_0077);
        check("lb_x0_w_e", {31'd0, r_w_e}, 32'd0);

        // SB 0x201
        run_mem(1'b1, 3'b000, 5'd14, 32'h0000_0201, 32'h0000_00AB, 0, 32'd0);
        check("sb_addr",  r_addr, 32'h0000_0200);
        check("sb_wstrb", {28'd0, r_wstrb}, 32'h2);
        check("sb_wdata", r_wdata, 32'hABAB_ABAB);
        check("sb_we",    {31'd0, r_we}, 32'd1);
        check("sb_w_e",   {31'd0, r_w_e}, 32'd0);

        // SH 0x202
        run_mem(1'b1, 3'b001, 5'd14, 32'h0000_0202, 32'h1234_CDEF, 1, 32'd0);
        check("sh_wstrb", {28'd0, r_wstrb}, 32'hC);
        check("sh_wdata", r_wdata, 32'hCDEF_CDEF);
        check("sh_w_e",   {31'd0, r_w_e}, 32'd0);

        // SW 0x204
        run_mem(1'b1, 3'b010, 5'd14, 32'h0000_0204, 32'h89AB_CDEF, 0, 32'd0);
        check("sw_wstrb", {28'd0, r_wstrb}, 32'hF);
        check("sw_wdata", r_wdata, 32'h89AB_CDEF);

        // Misaligned LW 0x102
        drive(1'b1, 1'b1, 5'd15, 32'h0000_0102, 1'b1, 1'b0, 3'b010, 32'd0);
        @(negedge clk_100MHz);
        check("mis_stall", {31'd0, stall_req_o}, 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0);
        @(negedge clk_100MHz);
        check("mis_pulse", {31'd0, misalign_o}, 32'd1);
        check("mis_req",   {31'd0, dmem_req_o}, 32'd0);
        check("mis_w_e",   {31'd0, w_e_o}, 32'd0);
        next_cycle();
        @(negedge clk_100MHz);
        check("mis_pulse_end", {31'd0, misalign_o}, 32'd0);
        check("mis_req2",      {31'd0, dmem_req_o}, 32'd0);
        next_cycle();

        // Reset while BUSY, then a stray ack in IDLE
        drive(1'b1, 1'b1, 5'd6, 32'h0000_0300, 1'b1, 1'b0, 3'b010, 32'd0);
        next_cycle();
        @(negedge clk_100MHz);
        check("busy_req", {31'd0, dmem_req_o}, 32'd1);
        arst_n = 1'b0;
        #1;
        check("arst_req",   {31'd0, dmem_req_o}, 32'd0);
        check("arst_stall", {31'd0, stall_req_o}, 32'd0);
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0);
        @(negedge clk_100MHz);
        arst_n = 1'b1;
        next_cycle();
        dmem_ack_i = 1'b1;
        dmem_rdata_i = 32'h1111_2222;
        @(negedge clk_100MHz);
        check("stray_ack_stall", {31'd0, stall_req_o}, 32'd0);
        next_cycle();
        dmem_ack_i = 1'b0;
        @(negedge clk_100MHz);
        check("stray_ack_w_e", {31'd0, w_e_o}, 32'd0);
        check("stray_ack_req", {31'd0, dmem_req_o}, 32'd0);
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
